// File: rtl/program_run_controller.sv
// program_run_controller: drives the processor init / restart / done handshake
// for a batch of runs, counts the cycles spent in each run and reports when
// the batch finishes.
//
// Optional feature: define PROGRAM_RUN_WATCHDOG_EN to enable the run watchdog.
// When it is enabled, a run that reaches MAX_CYCLES without done ends the batch
// and sets timed_out. When it is disabled, timed_out stays 0 and a run waits
// for done indefinitely.

module program_run_controller #(
    parameter int unsigned INIT_CYCLES = 1,        // 1..255
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned RUN_W       = 4,
    parameter int unsigned MAX_CYCLES  = 16'hFFFF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [RUN_W-1:0] num_runs,
    input  logic             done,
    output logic             init,
    output logic             restart,
    output logic             busy,
    output logic             finished,
    output logic             timed_out,
    output logic [RUN_W-1:0] run_index,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_RESTART,
        S_FINISH
    } state_t;

    // The INIT phase is timed by a down-counter. It is loaded with
    // INIT_CYCLES-1 when a batch starts, and RUN begins when it reaches 0.
    localparam logic [7:0] INIT_LOAD = 8'(INIT_CYCLES - 1);

`ifdef PROGRAM_RUN_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(MAX_CYCLES);

    state_t           state_q, state_n;
    logic             init_q, init_n;
    logic             restart_q, restart_n;
    logic             busy_q, busy_n;
    logic             finished_q, finished_n;
    logic             timed_out_q, timed_out_n;
    logic [RUN_W-1:0] run_index_q, run_index_n;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_n;
    logic [RUN_W-1:0] runs_q, runs_n;
    logic [7:0]       init_cnt_q, init_cnt_n;

    logic [RUN_W-1:0] run_next;
    logic [CNT_W-1:0] count_inc;
    logic             wd_hit;

    // Helper values for the RUN state: the run index after this completion,
    // the saturating cycle count, and the watchdog limit compare.
    assign run_next  = run_index_q + 1'b1;
    assign count_inc = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + 1'b1;
    assign wd_hit    = WD_EN && (cycle_count_q == WD_LIMIT);

    // Next-state and next-output logic. Every output is computed here and then
    // registered, so no input reaches an output without passing a flop.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can
        // leave a signal unassigned and infer a latch.
        state_n       = state_q;
        init_n        = 1'b0;
        restart_n     = 1'b0;
        busy_n        = busy_q;
        finished_n    = finished_q;
        timed_out_n   = timed_out_q;
        run_index_n   = run_index_q;
        cycle_count_n = cycle_count_q;
        runs_n        = runs_q;
        init_cnt_n    = init_cnt_q;

        if (state_q != S_IDLE && abort) begin
            // Cancel: return to IDLE. Progress is left visible, and finished
            // is not set.
            state_n = S_IDLE;
            busy_n  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_n       = S_INIT;
                        init_n        = 1'b1;
                        busy_n        = 1'b1;
                        finished_n    = 1'b0;
                        timed_out_n   = 1'b0;
                        run_index_n   = '0;
                        cycle_count_n = '0;
                        runs_n        = (num_runs == '0) ? RUN_W'(1) : num_runs;
                        init_cnt_n    = INIT_LOAD;
                    end
                end
                S_INIT: begin
                    if (init_cnt_q == 8'd0) begin
                        state_n = S_RUN;
                    end else begin
                        init_n     = 1'b1;
                        init_cnt_n = init_cnt_q - 8'd1;
                    end
                end
                S_RUN: begin
                    if (done) begin
                        run_index_n = run_next;
                        if (run_next == runs_q) begin
                            state_n       = S_FINISH;
                            cycle_count_n = count_inc;
                            finished_n    = 1'b1;
                            busy_n        = 1'b0;
                        end else begin
                            state_n       = S_RESTART;
                            restart_n     = 1'b1;
                            cycle_count_n = '0;
                        end
                    end else if (wd_hit) begin
                        state_n     = S_FINISH;
                        timed_out_n = 1'b1;
                        finished_n  = 1'b1;
                        busy_n      = 1'b0;
                    end else begin
                        cycle_count_n = count_inc;
                    end
                end
                S_RESTART: begin
                    state_n = S_RUN;
                end
                S_FINISH: begin
                    state_n = S_IDLE;
                end
                default: begin
                    state_n = S_IDLE;
                    busy_n  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers. An asynchronous reset forces every output
    // back to 0 at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            init_q        <= 1'b0;
            restart_q     <= 1'b0;
            busy_q        <= 1'b0;
            finished_q    <= 1'b0;
            timed_out_q   <= 1'b0;
            run_index_q   <= '0;
            cycle_count_q <= '0;
            runs_q        <= '0;
            init_cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register updates from
            // values taken before the clock edge.
            state_q       <= state_n;
            init_q        <= init_n;
            restart_q     <= restart_n;
            busy_q        <= busy_n;
            finished_q    <= finished_n;
            timed_out_q   <= timed_out_n;
            run_index_q   <= run_index_n;
            cycle_count_q <= cycle_count_n;
            runs_q        <= runs_n;
            init_cnt_q    <= init_cnt_n;
        end
    end

    assign init        = init_q;
    assign restart     = restart_q;
    assign busy        = busy_q;
    assign finished    = finished_q;
    assign timed_out   = timed_out_q;
    assign run_index   = run_index_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_program_run_controller.sv
// tb_program_run_controller: randomized batches checked against a
// transaction-level expectation. For each batch the bench derives the results
// (runs executed, restart pulses, final cycle count, flags) from the number of
// runs and the done delays it chose. It also covers the directed cases: abort,
// start while busy, done during INIT, reset mid-batch, and the watchdog.

module tb_program_run_controller;

    localparam int INIT_CYC = 1;
    localparam int CNT_W    = 16;
    localparam int RUN_W    = 4;
    localparam int MAX_CYC  = 8;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             done = 1'b0;
    logic [RUN_W-1:0] num_runs = '0;
    logic             init;
    logic             restart;
    logic             busy;
    logic             finished;
    logic             timed_out;
    logic [RUN_W-1:0] run_index;
    logic [CNT_W-1:0] cycle_count;

    program_run_controller #(
        .INIT_CYCLES(INIT_CYC),
        .CNT_W      (CNT_W),
        .RUN_W      (RUN_W),
        .MAX_CYCLES (MAX_CYC)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .num_runs   (num_runs),
        .done       (done),
        .init       (init),
        .restart    (restart),
        .busy       (busy),
        .finished   (finished),
        .timed_out  (timed_out),
        .run_index  (run_index),
        .cycle_count(cycle_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Handshake monitor, sampled on the falling edge: counts cycles with init
    // high, cycles with restart high, and rising edges of restart.
    int   init_hi  = 0;
    int   rst_hi   = 0;
    int   rst_rise = 0;
    logic rst_prev = 1'b0;
    always @(negedge clock) begin
        if (init)                 init_hi  <= init_hi + 1;
        if (restart)              rst_hi   <= rst_hi + 1;
        if (restart && !rst_prev) rst_rise <= rst_rise + 1;
        rst_prev <= restart;
    end

    int dly[16];  // done delay, in RUN cycles, for each run of the next batch

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start_batch(input int nr);
        num_runs = RUN_W'(nr);
        start    = 1'b1;
        step();
        start = 1'b0;
        check("start_init", init, 1);
        check("start_busy", busy, 1);
        check("start_finished", finished, 0);
        check("start_timed_out", timed_out, 0);
        check("start_run_index", run_index, 0);
        check("start_cycle_count", cycle_count, 0);
    endtask

    // One complete batch. noise=1 also drives random done during INIT and
    // RESTART, and pulses start with a different num_runs while busy.
    task automatic run_batch(input int nr, input bit noise);
        int eff;
        int i0;
        int r0;
        int q0;
        eff = (nr == 0) ? 1 : nr;
        i0  = init_hi;
        r0  = rst_hi;
        q0  = rst_rise;
        start_batch(nr);
        for (int c = 0; c < INIT_CYC; c++) begin
            done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) begin
                start    = 1'b1;
                num_runs = RUN_W'(eff + 1);
            end
            step();
            start = 1'b0;
        end
        for (int r = 0; r < eff; r++) begin
            for (int k = 1; k <= dly[r]; k++) begin
                check("run_cycle_count", cycle_count, k - 1);
                check("run_busy", busy, 1);
                check("run_init_low", init, 0);
                done = (k == dly[r]);
                if (noise && r == 0 && k == 1) begin
                    start    = 1'b1;
                    num_runs = RUN_W'(eff + 1);
                end
                step();
                start = 1'b0;
            end
            if (r < eff - 1) begin
                check("restart_high", restart, 1);
                check("restart_run_index", run_index, r + 1);
                done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                step();
                check("restart_dropped", restart, 0);
            end
        end
        done = 1'b0;
        check("fin_finished", finished, 1);
        check("fin_busy", busy, 0);
        check("fin_run_index", run_index, eff);
        check("fin_cycle_count", cycle_count, dly[eff-1]);
        check("fin_timed_out", timed_out, 0);
        step();
        check("idle_finished_sticky", finished, 1);
        check("idle_busy", busy, 0);
        check("idle_cycle_count_hold", cycle_count, dly[eff-1]);
        check("init_cycles", init_hi - i0, INIT_CYC);
        check("restart_cycles", rst_hi - r0, eff - 1);
        check("restart_pulses", rst_rise - q0, eff - 1);
    endtask

    initial begin
        int i0;
        int r0;

        // Outputs while reset is held.
        step();
        check("rst_init", init, 0);
        check("rst_restart", restart, 0);
        check("rst_busy", busy, 0);
        check("rst_finished", finished, 0);
        check("rst_timed_out", timed_out, 0);
        check("rst_run_index", run_index, 0);
        check("rst_cycle_count", cycle_count, 0);
        reset_n = 1'b1;
        step();

        // One run; done arrives in the 5th RUN cycle.
        dly[0] = 5;
        run_batch(1, 1'b0);

        // Three runs; done arrives after 4, 7 and 2 RUN cycles.
        dly[0] = 4; dly[1] = 7; dly[2] = 2;
        run_batch(3, 1'b0);

        // num_runs = 0 is treated as one run.
        dly[0] = $urandom_range(1, 9);
        run_batch(0, 1'b0);

        // done during INIT and start while busy are both ignored.
        dly[0] = 3; dly[1] = 1;
        run_batch(2, 1'b1);

        // start and abort together in IDLE: abort wins and the block stays IDLE.
        start = 1'b1; abort = 1'b1; num_runs = 4'd2;
        step();
        start = 1'b0; abort = 1'b0;
        check("idle_abort_busy", busy, 0);
        check("idle_abort_init", init, 0);
        step();
        check("idle_abort_stays", busy, 0);

        // Abort in RUN cycle 3 of run 2 of 3.
        start_batch(3);
        for (int c = 0; c < INIT_CYC; c++) step();
        dly[0] = $urandom_range(1, 9);
        for (int k = 1; k <= dly[0]; k++) begin
            done = (k == dly[0]);
            step();
        end
        done = 1'b0;
        step();                        // RESTART cycle
        step();                        // RUN cycle 1
        step();                        // RUN cycle 2
        abort = 1'b1;
        step();                        // abort sampled in RUN cycle 3
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_finished", finished, 0);
        check("abort_run_index", run_index, 1);
        check("abort_cycle_count", cycle_count, 2);
        check("abort_init", init, 0);
        check("abort_restart", restart, 0);
        i0 = init_hi;
        r0 = rst_hi;
        for (int c = 0; c < 10; c++) begin
            done = 1'($urandom_range(0, 1));
            step();
        end
        done = 1'b0;
        check("abort_no_init", init_hi - i0, 0);
        check("abort_no_restart", rst_hi - r0, 0);
        check("abort_stays_idle", busy, 0);

        // Reset asserted in the middle of a batch.
        start_batch(2);
        for (int c = 0; c < INIT_CYC + 2; c++) step();
        reset_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_cycle_count", cycle_count, 0);
        check("midrst_init", init, 0);
        step();
        reset_n = 1'b1;
        step();

        // Randomized batches.
        for (int b = 0; b < 5; b++) begin
            for (int r = 0; r < 16; r++) dly[r] = $urandom_range(1, 9);
            run_batch($urandom_range(0, 5), 1'($urandom_range(0, 1)));
        end

        // Watchdog: done is never asserted.
        start_batch(1);
        for (int c = 0; c < INIT_CYC; c++) step();
`ifdef PROGRAM_RUN_WATCHDOG_EN
        for (int c = 0; c < MAX_CYC + 1; c++) step();
        check("wd_timed_out", timed_out, 1);
        check("wd_finished", finished, 1);
        check("wd_busy", busy, 0);
        check("wd_cycle_count", cycle_count, MAX_CYC);
        check("wd_run_index", run_index, 0);
        step();
        check("wd_timed_out_sticky", timed_out, 1);
`else
        for (int c = 0; c < 100; c++) step();
        check("nowd_busy", busy, 1);
        check("nowd_timed_out", timed_out, 0);
        check("nowd_cycle_count", cycle_count, 100);
        check("nowd_run_index", run_index, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("nowd_abort_busy", busy, 0);
`endif
        // The next accepted start clears the sticky flags.
        dly[0] = 2;
        run_batch(1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/program_run_controller.md
Name: program_run_controller

Overview:
- Hardware initiator for the processor run handshake (init / restart / done).
- Drives init and restart into a processor core, waits for done, and repeats for a programmed number of runs.
- Measures cycles per run and reports completion.
- Sits between the host or boot logic and a processor_N instance; replaces bench-driven init/restart sequencing in system builds.

Parameters:
- INIT_CYCLES, 1, number of clock cycles init is held high at the start of a batch (1..255).
- CNT_W, 16, width of the cycle counter.
- RUN_W, 4, width of the run-count input and run index.
- MAX_CYCLES, 16'hFFFF, watchdog limit in cycles (used only with the optional feature).

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin a batch; sampled only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE
- num_runs  in  RUN_W  runs per batch; latched on accepted start; 0 treated as 1
- done  in  1  processor completion flag
- init  out  1  processor init, registered
- restart  out  1  processor restart, registered
- busy  out  1  batch in progress
- finished  out  1  sticky: batch complete; cleared on next accepted start
- timed_out  out  1  sticky: watchdog fired; cleared on next accepted start
- run_index  out  RUN_W  runs completed in the current batch
- cycle_count  out  CNT_W  cycles of the current or last run

Behaviour:
- Reset (async, reset_n=0): state=IDLE; init=0, restart=0, busy=0, finished=0, timed_out=0, run_index=0, cycle_count=0.
- All outputs are registered; no combinational path from input to output.
- IDLE:
  - start=1 at edge N: latch num_runs, clear finished, timed_out, run_index and cycle_count.
  - Go to INIT; init=1 and busy=1 are visible after edge N.
- INIT:
  - init=1 for exactly INIT_CYCLES cycles, then RUN.
  - done is ignored.
  - cycle_count is held at 0.
- RUN:
  - init=0, restart=0.
  - cycle_count increments each cycle, saturating at all-ones.
  - On done=1: run_index+1.
  - If the new run_index equals the latched runs, go to FINISH; otherwise go to RESTART.
- RESTART:
  - restart=1 for exactly 1 cycle; cycle_count cleared to 0; then RUN.
  - done is ignored in this cycle.
- FINISH (1 cycle): finished=1, busy=0, then IDLE.
- cycle_count holds its final value in IDLE.
- done=1 held continuously across a RESTART: the first RUN cycle samples it as a new completion. The processor must drop done on restart.
- abort=1 in any non-IDLE state: next edge returns to IDLE.
  - init=0, restart=0, busy=0.
  - finished stays 0; run_index and cycle_count hold.
  - abort has priority over done and the watchdog in the same cycle.
- start while busy: ignored. start and abort together in IDLE: abort wins, stay IDLE.
- reset_n asserted mid-batch: immediate return to reset values.

Optional Feature:
- Macro: PROGRAM_RUN_WATCHDOG_EN.
- When defined:
  - In RUN, if cycle_count reaches MAX_CYCLES with done=0, the next edge sets timed_out=1 and enters FINISH.
  - finished=1 and remaining runs are skipped.
  - run_index is not incremented.
  - done and the watchdog in the same cycle: done wins.
- When undefined: timed_out is tied to 0, MAX_CYCLES is unused, and RUN waits for done indefinitely.

Test Plan:
- Reset release, then start=1 for 1 cycle with num_runs=1, INIT_CYCLES=1, done at the 5th RUN cycle:
  - init high exactly 1 cycle;
  - finished=1, run_index=1, cycle_count=5, busy=0.
- num_runs=3, done after 4, 7 and 2 RUN cycles:
  - restart pulses exactly twice, 1 cycle each;
  - final cycle_count=2, run_index=3, finished=1.
- num_runs=0: behaves as 1 run; finished after the first done; run_index=1.
- abort asserted at RUN cycle 3 of run 2 of 3:
  - IDLE next cycle; busy=0, finished=0, run_index=1;
  - no further init or restart.
- done=1 during INIT, and start pulsed while busy: both ignored; the batch proceeds normally.
- With PROGRAM_RUN_WATCHDOG_EN and MAX_CYCLES=8, done never asserted:
  - timed_out=1, finished=1, cycle_count=8, run_index=0.
  - Without the macro, busy stays 1 after 100 cycles.
